// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit pair per clock, LSD first, valid/ready on both sides.
// Define BCD_SUB_EN to add a 'sub' input that computes A - B by ten's complement.
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  c_in,
`ifdef BCD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  c_out,
  output logic                  err
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] a_q, b_q, sum_q, sum_d;
  logic [IdxW-1:0]     idx_q;
  logic                carry_q, c_out_q, err_q;
  logic [3:0]          a_dig, b_dig, b_eff, res_dig;
  logic [4:0]          s;
  logic                carry_n, digit_err, last_digit;
`ifdef BCD_SUB_EN
  logic                sub_q;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (op_valid)   state_d = StAdd;
      StAdd:   if (last_digit) state_d = StDone;
      StDone:  if (res_ready)  state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    op_ready  = (state_q == StIdle);
    res_valid = (state_q == StDone);
  end

  // Digit select and decimal-corrected digit add
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
    // Range check uses the raw B digit, before any complementing
    digit_err = (a_dig > 4'd9) || (b_dig > 4'd9);
`ifdef BCD_SUB_EN
    b_eff = sub_q ? (4'd9 - b_dig) : b_dig;
`else
    b_eff = b_dig;
`endif
    s          = {1'b0, a_dig} + {1'b0, b_eff} + {4'd0, carry_q};
    carry_n    = (s > 5'd9);
    res_dig    = carry_n ? (s[3:0] + 4'd6) : s[3:0];
    last_digit = (idx_q == IdxW'(DIGITS - 1));
    sum_d      = sum_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        sum_d[4*i +: 4] = res_dig;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (op_valid) begin
            a_q   <= a;
            b_q   <= b;
            idx_q <= '0;
            err_q <= 1'b0;
`ifdef BCD_SUB_EN
            sub_q   <= sub;
            carry_q <= sub ? 1'b1 : c_in;
`else
            carry_q <= c_in;
`endif
          end
        end
        StAdd: begin
          sum_q   <= sum_d;
          carry_q <= carry_n;
          err_q   <= err_q | digit_err;
          if (last_digit) begin
            c_out_q <= carry_n;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder (DIGITS=4).
module tb_bcd_serial_adder;

  localparam int unsigned DIGITS = 4;

  logic        clk, rst_n, op_valid, op_ready, c_in, res_valid, res_ready, c_out, err;
  logic [15:0] a, b, sum;
`ifdef BCD_SUB_EN
  logic        sub;
`endif
  int tests  = 0;
  int failed = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
`ifdef BCD_SUB_EN
    .sub      (sub),
`endif
    .res_valid(res_valid),
    .res_ready(res_ready),
    .sum      (sum),
    .c_out    (c_out),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
    int n = 0;
    while (!op_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("op_ready_wait", {31'd0, op_ready}, 32'd1);
    a = ta; b = tb_; c_in = tc; op_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs: the block must work from its latched copies
    op_valid = 1'b0; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
  endtask

  task automatic wait_result(input string tag);
    int lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, lat, DIGITS);
  endtask

  task automatic finish_op(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_op_ready"}, {31'd0, op_ready}, 32'd1);
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic [15:0] esum, input logic ec, input logic ee);
    start_op(ta, tb_, tc);
    wait_result(tag);
    check({tag, "_sum"}, {16'd0, sum}, {16'd0, esum});
    check({tag, "_c_out"}, {31'd0, c_out}, {31'd0, ec});
    check({tag, "_err"}, {31'd0, err}, {31'd0, ee});
    finish_op(tag);
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
`ifdef BCD_SUB_EN
    sub = 1'b0;
`endif
    #12;
    check("rst_op_ready", {31'd0, op_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_c_out", {31'd0, c_out}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_basic", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("add_wrap",  16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_cin",   16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
    run_op("bad_digit", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);

    // Backpressure: result held, new operands refused
    start_op(16'h0001, 16'h0001, 1'b0);
    wait_result("bp");
    check("bp_err_cleared", {31'd0, err}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        a = 16'h4444; b = 16'h4444; op_valid = 1'b1;
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
      check("bp_res_valid", {31'd0, res_valid}, 32'd1);
      check("bp_op_ready", {31'd0, op_ready}, 32'd0);
      check("bp_sum", {16'd0, sum}, 32'h0002);
      check("bp_c_out", {31'd0, c_out}, 32'd0);
    end
    finish_op("bp");
    check("bp_sum_after", {16'd0, sum}, 32'h0002);

    // Asynchronous reset while digit 2 is being processed
    start_op(16'h1111, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_sum_partial", {16'd0, sum}, 32'h0022);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_op_ready", {31'd0, op_ready}, 32'd1);
    check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("mid_rst_sum", {16'd0, sum}, 32'd0);
    check("mid_rst_c_out", {31'd0, c_out}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    check("mid_rst_held", {31'd0, res_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0);

`ifdef BCD_SUB_EN
    sub = 1'b1;
    start_op(16'h5000, 16'h1234, 1'b0);
    sub = 1'b0;
    wait_result("sub_pos");
    check("sub_pos_sum", {16'd0, sum}, 32'h3766);
    check("sub_pos_c_out", {31'd0, c_out}, 32'd1);
    finish_op("sub_pos");
    sub = 1'b1;
    start_op(16'h1234, 16'h5000, 1'b0);
    sub = 1'b0;
    wait_result("sub_neg");
    check("sub_neg_sum", {16'd0, sum}, 32'h6234);
    check("sub_neg_c_out", {31'd0, c_out}, 32'd0);
    finish_op("sub_neg");
    run_op("sub_off", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
